// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALUsel codes, FSM states, port count.
// Used by alu_arbiter and Alu via import alu_pkg::*.
package alu_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// RV32I ALU shared by the arbiter. Shift amounts use rs2[4:0]; any code not
// listed in alu_pkg falls through to addition.
module Alu
    import alu_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [3:0]  ALUsel,
    output logic [31:0] rd
);

    // Pure combinational operation select
    always_comb begin
        rd = rs1 + rs2;
        case (ALUsel)
            ALU_ADD: rd = rs1 + rs2;
            ALU_SLL: rd = rs1 << rs2[4:0];
            ALU_XOR: rd = rs1 ^ rs2;
            ALU_SRL: rd = rs1 >> rs2[4:0];
            ALU_OR:  rd = rs1 | rs2;
            ALU_AND: rd = rs1 & rs2;
            ALU_SUB: rd = rs1 - rs2;
            ALU_SRA: rd = $unsigned($signed(rs1) >>> rs2[4:0]);
            default: rd = rs1 + rs2;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one Alu through an IDLE/EXEC/RESP FSM.
// Round-robin arbitration by default; define ALU_ARBITER_FIXED_PRIO_EN to make
// port 0 always win contention (the last-grant pointer then disappears).
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [3:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic [3:0]  req1_sel,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_data,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_data,
    output logic        busy
);

    state_e      state_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [3:0]  sel_q;
    logic        grant_q;
    logic [31:0] result_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
    logic        lastGrant_q;
`endif

    logic [NUM_PORTS-1:0] reqValid;
    logic                 grant_d;
    logic                 accept;
    logic                 respAck;
    logic [31:0]          aluRd;

    assign reqValid = {req1_valid, req0_valid};

    // Pick the port to serve if we are idle; only meaningful when accept is high
    always_comb begin
        grant_d = 1'b0;
        if (reqValid == 2'b11) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            grant_d = 1'b0;
`else
            grant_d = ~lastGrant_q;
`endif
        end else if (reqValid[1]) begin
            grant_d = 1'b1;
        end
    end

    assign accept     = (state_q == ST_IDLE) && (reqValid != '0);
    assign req0_ready = accept && !grant_d;
    assign req1_ready = accept && grant_d;

    assign resp0_valid = (state_q == ST_RESP) && !grant_q;
    assign resp1_valid = (state_q == ST_RESP) && grant_q;
    assign resp0_data  = resp0_valid ? result_q : '0;
    assign resp1_data  = resp1_valid ? result_q : '0;
    assign respAck     = grant_q ? resp1_ready : resp0_ready;
    assign busy        = (state_q != ST_IDLE);

    Alu uAlu (
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .ALUsel (sel_q),
        .rd     (aluRd)
    );

    // FSM: capture the granted request, run it through the ALU, hold the result until acknowledged
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            sel_q       <= '0;
            grant_q     <= 1'b0;
            result_q    <= '0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            lastGrant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q <= grant_d;
                        rs1_q   <= grant_d ? req1_rs1 : req0_rs1;
                        rs2_q   <= grant_d ? req1_rs2 : req0_rs2;
                        sel_q   <= grant_d ? req1_sel : req0_sel;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= aluRd;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (respAck) begin
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                        lastGrant_q <= grant_q;
`endif
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter. Expected results are pushed on accept and
// popped by an independent monitor whenever a response handshake completes.
// Contention expectations follow ALU_ARBITER_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [3:0]  req0_sel, req1_sel;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_data, resp1_data;
    logic        busy;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sbQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_rs1    (req0_rs1),
        .req0_rs2    (req0_rs2),
        .req0_sel    (req0_sel),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_rs1    (req1_rs1),
        .req1_rs2    (req1_rs2),
        .req1_sel    (req1_sel),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data),
        .busy        (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic respValid(input int p);
        return (p == 0) ? resp0_valid : resp1_valid;
    endfunction

    task automatic popCheck(input logic p, input logic [31:0] data);
        exp_t e;
        if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_resp: port %0d gave 0x%08h, expected no response", p, data);
        end else begin
            e = sbQ.pop_front();
            checkOutput("resp_port", {31'b0, p}, {31'b0, e.port});
            checkOutput("resp_data", data, e.data);
        end
    endtask

    // Monitor: consume a scoreboard entry on every completed response handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (resp0_valid && resp0_ready) popCheck(1'b0, resp0_data);
            if (resp1_valid && resp1_ready) popCheck(1'b1, resp1_data);
            if (!resp0_valid) checkOutput("resp0_data_zero_when_idle", resp0_data, 32'h0);
            if (!resp1_valid) checkOutput("resp1_data_zero_when_idle", resp1_data, 32'h0);
            checkOutput("single_resp_valid", {31'b0, resp0_valid & resp1_valid}, 32'h0);
        end
    end

    task automatic setReq(input int port, input logic v, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0_valid = v; req0_sel = sel; req0_rs1 = a; req0_rs2 = b;
        end else begin
            req1_valid = v; req1_sel = sel; req1_rs1 = a; req1_rs2 = b;
        end
    endtask

    // Poll for ready on a port; on success optionally push the expected response
    task automatic waitAccept(input int port, input logic [31:0] expData, input bit doPush);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) ok = 1'b1;
        end
        checkOutput((port == 0) ? "accept_port0" : "accept_port1", {31'b0, ok}, 32'h1);
        if (ok && doPush) begin
            e.port = (port != 0);
            e.data = expData;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        checkOutput("return_to_idle", {31'b0, idle}, 32'h1);
    endtask

    // One complete operation on one port, including the two-cycle latency check
    task automatic applyStimulus(input int port, input logic [3:0] sel,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] expData);
        @(posedge clk); #1;
        setReq(port, 1'b1, sel, a, b);
        waitAccept(port, expData, 1'b1);
        @(posedge clk); #1;
        setReq(port, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("exec_resp_valid_low", {31'b0, respValid(port)}, 32'h0);
        checkOutput("exec_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        checkOutput("latency2_resp_valid", {31'b0, respValid(port)}, 32'h1);
        checkOutput("other_resp_valid_low", {31'b0, respValid(port == 0 ? 1 : 0)}, 32'h0);
        waitIdle();
    endtask

    localparam int NVEC = 8;
    int          vPort [NVEC] = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic [3:0]  vSel  [NVEC] = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_SRL, ALU_SLL, 4'b0010, ALU_OR, ALU_AND};
    logic [31:0] vA    [NVEC] = '{32'd5, 32'd3, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd10, 32'h1200_0034, 32'hF0F0_FFFF};
    logic [31:0] vB    [NVEC] = '{32'd7, 32'd5, 32'd4, 32'd4, 32'd35, 32'd20, 32'h0034_5600, 32'h0FF0_00FF};
    logic [31:0] vExp  [NVEC] = '{32'h0000_000C, 32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000,
                                  32'h0000_0008, 32'h0000_001E, 32'h1234_5634, 32'h00F0_00FF};

    initial begin
        rst = 1'b1;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        setReq(0, 1'b0, 4'h0, 32'h0, 32'h0);
        setReq(1, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_resp0_valid", {31'b0, resp0_valid}, 32'h0);
        checkOutput("reset_resp1_valid", {31'b0, resp1_valid}, 32'h0);
        checkOutput("reset_resp0_data", resp0_data, 32'h0);
        checkOutput("reset_req_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention right after reset: port 0 first, then port 0 re-requests
        setReq(0, 1'b1, ALU_SLL, 32'd1, 32'd35);
        setReq(1, 1'b1, ALU_XOR, 32'h0000_00F0, 32'h0000_00FF);
        waitAccept(0, 32'h0000_0008, 1'b1);
        checkOutput("contend_req1_ready_low", {31'b0, req1_ready}, 32'h0);
        @(posedge clk); #1;
        setReq(0, 1'b1, ALU_ADD, 32'd2, 32'd2);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        waitAccept(0, 32'h0000_0004, 1'b1);
        checkOutput("fixed_req1_ready_low", {31'b0, req1_ready}, 32'h0);
        @(posedge clk); #1;
        setReq(0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitAccept(1, 32'h0000_000F, 1'b1);
        @(posedge clk); #1;
        setReq(1, 1'b0, 4'h0, 32'h0, 32'h0);
`else
        waitAccept(1, 32'h0000_000F, 1'b1);
        checkOutput("rr_req0_ready_low", {31'b0, req0_ready}, 32'h0);
        @(posedge clk); #1;
        setReq(1, 1'b0, 4'h0, 32'h0, 32'h0);
        waitAccept(0, 32'h0000_0004, 1'b1);
        @(posedge clk); #1;
        setReq(0, 1'b0, 4'h0, 32'h0, 32'h0);
`endif
        waitIdle();

        // Directed single-port vectors
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vPort[i], vSel[i], vA[i], vB[i], vExp[i]);
        end

        // Back-pressure on port 0 while port 1 waits
        @(posedge clk); #1;
        resp0_ready = 1'b0;
        setReq(0, 1'b1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        waitAccept(0, 32'h0F00_0F00, 1'b1);
        @(posedge clk); #1;
        setReq(0, 1'b0, 4'h0, 32'h0, 32'h0);
        setReq(1, 1'b1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_resp0_valid", {31'b0, resp0_valid}, 32'h1);
            checkOutput("hold_resp0_data", resp0_data, 32'h0F00_0F00);
            checkOutput("hold_busy", {31'b0, busy}, 32'h1);
            checkOutput("hold_req1_ready_low", {31'b0, req1_ready}, 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp0_ready = 1'b1;
        waitAccept(1, 32'h1234_5678, 1'b1);
        @(posedge clk); #1;
        setReq(1, 1'b0, 4'h0, 32'h0, 32'h0);
        waitIdle();

        // Reset while the operation is in EXEC drops it silently
        @(posedge clk); #1;
        setReq(0, 1'b1, ALU_ADD, 32'd100, 32'd200);
        waitAccept(0, 32'h0, 1'b0);
        @(posedge clk); #1;
        setReq(0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_exec_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_exec_resp_valid", {30'b0, resp1_valid, resp0_valid}, 32'h0);
        checkOutput("rst_exec_resp0_data", resp0_data, 32'h0);
        checkOutput("rst_exec_req_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("dropped_no_resp", {31'b0, resp0_valid}, 32'h0);
        end

        // Fresh operation after the dropped one still works
        applyStimulus(0, ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide ports in this order: clk  in  1  single clock, all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 reqN_valid  in  1  (N = 0,1): requester N presents an operation.
REQ-004 reqN_ready  out  1  (N = 0,1): operation accepted this cycle.
REQ-005 reqN_rs1, reqN_rs2  in  32 each  (N = 0,1): operands.
REQ-006 reqN_sel  in  4  (N = 0,1): ALU select code, RV32I ALUsel encoding.
REQ-007 respN_valid  out  1  (N = 0,1): result available for requester N.
REQ-008 respN_ready  in  1  (N = 0,1): requester N consumes result.
REQ-009 respN_data  out  32  (N = 0,1): result.
REQ-010 busy  out  1  high whenever state is not IDLE.

Function
REQ-011 SHALL share one ALU between two requesters using FSM states IDLE, EXEC, RESP.
REQ-012 IDLE: with at least one reqN_valid, SHALL grant one port, assert its reqN_ready combinationally that cycle, register rs1/rs2/sel/grant, and go to EXEC.
REQ-013 SHALL hold reqN_ready low for the non-granted port and low in EXEC and RESP.
REQ-014 EXEC: SHALL feed the registered operands to the ALU, register the ALU result, and go to RESP.
REQ-015 RESP: SHALL assert respN_valid for the granted port only; respN_data SHALL equal the registered result and stay stable while valid.
REQ-016 RESP with respN_ready high: SHALL deassert respN_valid next cycle, update the last-grant pointer, and return to IDLE.
REQ-017 Latency: accept on cycle T, respN_valid high from cycle T+2; at most one operation every 3 cycles.
REQ-018 Arbitration: round-robin. With both valid, the port not granted last wins; with one valid, it wins regardless of the pointer.
REQ-019 Unknown sel codes SHALL be passed to the ALU unchanged; the result is the ALU default (add).
REQ-020 respN_data SHALL read zero whenever respN_valid is low.

Reset
REQ-021 On rst: state IDLE; reqN_ready 0; respN_valid 0; respN_data 0; busy 0; operand/result registers 0; last-grant = port 1, so port 0 wins the first contention.
REQ-022 rst in EXEC or RESP SHALL drop the in-flight operation with no response emitted.

Configuration
REQ-023 Macro ALU_ARBITER_FIXED_PRIO_EN defined: port 0 always wins contention and the last-grant pointer is removed.
REQ-024 Macro undefined: round-robin per REQ-018.

Structure
REQ-025 Shared package alu_pkg SHALL hold the ALUsel code constants (ADD 0000, SLL 0001, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101), the FSM state typedef, and the port-count constant 2.
REQ-026 SHALL instantiate exactly one sub-module: Alu (the team's RV32I ALU; ports rs1, rs2, ALUsel, rd).

Verification
REQ-027 Port 0 ADD, rs1=5, rs2=7 -> resp0_valid 2 cycles after accept, resp0_data=0x0000000C.
REQ-028 Port 1 SUB, rs1=3, rs2=5 -> resp1_data=0xFFFFFFFE; resp0_valid stays 0.
REQ-029 Both ports valid right after reset (port 0 SLL 1,35; port 1 XOR 0xF0,0xFF) -> port 0 served first with 0x00000008, then port 1 with 0x0000000F; with FIXED_PRIO_EN and port 0 re-requesting, port 0 is served again.
REQ-030 resp0_ready held low 5 cycles in RESP -> resp0_valid and data held, busy=1, req1_ready stays 0; grant to port 1 follows the release.
REQ-031 rst asserted in EXEC -> next cycle all outputs 0 and state IDLE; no response for the dropped operation.
